pwm_ramp_scheduler: RTL and testbench

//  Owns the duty-cycle bus that feeds the multi-channel PWM comparator bank
//  (byte 0 reserved, bytes 1..NUM_CH = heater/light channels + extract vent).

---
 rtl/pwm_ramp_scheduler_if.sv | 11 +
 rtl/pwm_ramp_scheduler.sv | 144 ++++++++++++++
 tb/tb_pwm_ramp_scheduler.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_ramp_scheduler_if.sv
// Target-write port between the command decoder (master) and the PWM ramp scheduler (slave).
`timescale 1ns/1ps
interface pwm_ramp_scheduler_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_chan;
    logic [7:0] wr_duty;

    modport master (output wr_valid, output wr_chan, output wr_duty, input wr_ready);
    modport slave  (input wr_valid, input wr_chan, input wr_duty, output wr_ready);
endinterface

// File: rtl/pwm_ramp_scheduler.sv
// Slews per-channel PWM duties toward their targets once per step tick and
// commits the whole duty bus in a single edge so comparators never see a mixed set.
`timescale 1ns/1ps
module pwm_ramp_scheduler #(
    parameter int NUM_CH   = 10,
    parameter int STEP     = 4,
    parameter int STEP_DIV = 25000
) (
    input  logic                    clk25M,
    input  logic                    rst,
    pwm_ramp_scheduler_if.slave     wr,
    input  logic                    force_off,
    output logic [8*(NUM_CH+1)-1:0] duty_bus,
    output logic                    busy,
    output logic                    wr_err
);
    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_CH - 1);
    localparam logic [3:0]        NUM_CH_C = 4'(NUM_CH);
    localparam logic signed [8:0] STEP_S   = 9'(STEP);
    localparam logic [7:0]        STEP_U   = 8'(STEP);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic             rdy_q, err_q, busy_q, busy_d;
    logic [7:0]       target_q [NUM_CH];
    logic [7:0]       shadow_q [NUM_CH];
    logic [7:0]       bus_q    [NUM_CH];
    logic [7:0]       shadow_d;
    logic             wr_accept, chan_ok;
    logic [IDX_W-1:0] wr_idx;

    // One slew step: move by at most STEP, land exactly on the target when within reach.
    function automatic logic [7:0] slew(input logic [7:0] tgt, input logic [7:0] cur);
        logic signed [8:0] d;
        d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (d > STEP_S)
            slew = cur + STEP_U;
        else if (d < -STEP_S)
            slew = cur - STEP_U;
        else
            slew = tgt;
    endfunction

    assign wr.wr_ready = rdy_q;
    assign wr_accept   = wr.wr_valid & rdy_q;
    assign chan_ok     = (wr.wr_chan < NUM_CH_C);
    assign wr_idx      = wr.wr_chan[IDX_W-1:0];
    assign shadow_d    = slew(target_q[idx_q], shadow_q[idx_q]);
    assign busy        = busy_q;
    assign wr_err      = err_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tick    = (div_q == DIV_LAST);
        div_d   = tick ? '0 : div_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (idx_q == IDX_LAST)
                    state_d = COMMIT;
                else
                    idx_d = idx_q + 1'b1;
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Emergency off aborts any scan and freezes the divider at zero.
        if (force_off) begin
            state_d = IDLE;
            idx_d   = '0;
            div_d   = '0;
        end
    end

    always_comb begin
        busy_d = 1'b0;
        for (int k = 0; k < NUM_CH; k++)
            busy_d = busy_d | (target_q[k] != shadow_q[k]) | (bus_q[k] != shadow_q[k]);
        if (force_off)
            busy_d = 1'b0;
    end

    always_comb begin
        duty_bus = '0;
        for (int k = 0; k < NUM_CH; k++)
            duty_bus[8*(k+1) +: 8] = bus_q[k];
    end

    always_ff @(posedge clk25M or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            div_q   <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            div_q   <= div_d;
            rdy_q   <= ~force_off;
            err_q   <= wr_accept & ~chan_ok;
            busy_q  <= busy_d;
        end
    end

    // Scan reads the target before a same-edge write lands, so a racing write waits a tick.
    always_ff @(posedge clk25M or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                target_q[k] <= 8'h00;
                shadow_q[k] <= 8'h00;
                bus_q[k]    <= 8'h00;
            end
        end else if (force_off) begin
            for (int k = 0; k < NUM_CH; k++) begin
                target_q[k] <= 8'h00;
                shadow_q[k] <= 8'h00;
                bus_q[k]    <= 8'h00;
            end
        end else begin
            if (wr_accept && chan_ok)
                target_q[wr_idx] <= wr.wr_duty;
            if (state_q == SCAN)
                shadow_q[idx_q] <= shadow_d;
            if (state_q == COMMIT)
                for (int k = 0; k < NUM_CH; k++)
                    bus_q[k] <= shadow_q[k];
        end
    end
endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// Scoreboard bench for pwm_ramp_scheduler: stimulus pushes expected bus images,
// a negedge monitor pops one per observed bus change and checks commit latency.
`timescale 1ns/1ps
module tb_pwm_ramp_scheduler;
    localparam int NCH = 10;
    localparam int BW  = 8*(NCH+1);

    typedef struct {
        logic [BW-1:0] bus;
        bit            timed;
    } exp_t;

    logic          clk25M;
    logic          rst;
    logic          force_off;
    logic [BW-1:0] duty_bus;
    logic          busy;
    logic          wr_err;

    pwm_ramp_scheduler_if wif ();

    pwm_ramp_scheduler #(.NUM_CH(NCH), .STEP(8), .STEP_DIV(16)) dut (
        .clk25M   (clk25M),
        .rst      (rst),
        .wr       (wif),
        .force_off(force_off),
        .duty_bus (duty_bus),
        .busy     (busy),
        .wr_err   (wr_err)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    int   edge_cnt = 0;
    int   last_tick = -1000;
    int   div_m = 0;
    logic [7:0] ed [NCH];
    exp_t exp_q [$];
    int   err_q [$];

    initial begin
        clk25M = 1'b0;
        forever #5 clk25M = ~clk25M;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] pack();
        logic [BW-1:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++) r[8*(k+1) +: 8] = ed[k];
        return r;
    endfunction

    task automatic push_exp(input bit timed);
        exp_t e;
        e.bus   = pack();
        e.timed = timed;
        exp_q.push_back(e);
    endtask

    // Reference step-tick timing: a tick acts on the edge where the count was 15.
    initial begin
        forever begin
            @(posedge clk25M);
            edge_cnt++;
            if (rst || force_off) div_m = 0;
            else if (div_m == 15) begin
                div_m = 0;
                last_tick = edge_cnt;
            end else div_m++;
        end
    end

    initial begin
        logic [BW-1:0] mon_prev;
        exp_t          mon_e;
        mon_prev = '0;
        forever begin
            @(negedge clk25M);
            if (duty_bus !== mon_prev) begin
                if (exp_q.size() == 0) check("unexpected_bus_change", duty_bus, mon_prev);
                else begin
                    mon_e = exp_q.pop_front();
                    check("duty_bus", duty_bus, mon_e.bus);
                    if (mon_e.timed) check("commit_latency", edge_cnt - last_tick, 11);
                end
                mon_prev = duty_bus;
            end
            if (wr_err === 1'b1) begin
                if (err_q.size() == 0) check("unexpected_wr_err", wr_err, 0);
                else check("wr_err_edge", edge_cnt, err_q.pop_front());
            end
        end
    end

    task automatic do_write(input logic [3:0] ch, input logic [7:0] d);
        wif.wr_valid = 1'b1;
        wif.wr_chan  = ch;
        wif.wr_duty  = d;
        @(posedge clk25M);
        #1;
        wif.wr_valid = 1'b0;
        if (ch >= NCH) err_q.push_back(edge_cnt);
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(posedge clk25M);
            #1;
            n++;
        end while (last_tick != edge_cnt && n < 64);
        check("tick_wait", last_tick == edge_cnt, 1);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk25M);
            n++;
        end
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        force_off = 1'b0;
        wif.wr_valid = 1'b0;
        wif.wr_chan = 4'd0;
        wif.wr_duty = 8'd0;
        for (int k = 0; k < NCH; k++) ed[k] = 8'd0;
        repeat (3) @(posedge clk25M);
        #1;
        check("rst_bus", duty_bus, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", wif.wr_ready, 0);
        check("rst_err", wr_err, 0);
        rst = 1'b0;
        check("ready_before_edge", wif.wr_ready, 0);
        @(posedge clk25M);
        #1;
        check("ready_after_release", wif.wr_ready, 1);

        // Ramp up ch0 to 100 in steps of 8
        do_write(4'd0, 8'd100);
        @(posedge clk25M);
        #1;
        check("busy_ramping", busy, 1);
        for (int v = 8; v <= 96; v += 8) begin
            ed[0] = 8'(v);
            push_exp(1'b1);
        end
        ed[0] = 8'd100;
        push_exp(1'b1);
        wait_drain(400);
        check("busy_settled", busy, 0);

        // Ramp down and exact landing on ch9
        do_write(4'd9, 8'd20);
        ed[9] = 8'd8;  push_exp(1'b1);
        ed[9] = 8'd16; push_exp(1'b1);
        ed[9] = 8'd20; push_exp(1'b1);
        wait_drain(100);
        do_write(4'd9, 8'd13);
        ed[9] = 8'd13; push_exp(1'b1);
        wait_drain(60);
        do_write(4'd9, 8'd0);
        ed[9] = 8'd5; push_exp(1'b1);
        ed[9] = 8'd0; push_exp(1'b1);
        wait_drain(80);

        // Race: write ch3 in the same cycle its scan slot samples the target
        do_write(4'd3, 8'd16);
        ed[3] = 8'd8;  push_exp(1'b1);
        ed[3] = 8'd16; push_exp(1'b1);
        wait_drain(80);
        wait_tick();
        do_write(4'd3, 8'd20);
        repeat (2) @(posedge clk25M);
        #1;
        do_write(4'd3, 8'd200);
        ed[3] = 8'd20; push_exp(1'b1);
        for (int v = 28; v <= 196; v += 8) begin
            ed[3] = 8'(v);
            push_exp(1'b1);
        end
        ed[3] = 8'd200;
        push_exp(1'b1);
        wait_drain(500);

        // Out-of-range channel
        do_write(4'd12, 8'd77);
        repeat (40) @(posedge clk25M);
        #1;
        check("bus_after_bad_chan", duty_bus, pack());
        check("busy_after_bad_chan", busy, 0);

        // force_off during a scan with every channel ramping
        wait_tick();
        repeat (11) @(posedge clk25M);
        #1;
        for (int k = 0; k < NCH; k++) begin
            wif.wr_valid = 1'b1;
            wif.wr_chan  = 4'(k);
            wif.wr_duty  = 8'd255;
            @(posedge clk25M);
            #1;
        end
        wif.wr_valid = 1'b0;
        for (int k = 0; k < NCH; k++) ed[k] = 8'd8;
        ed[0] = 8'd108;
        ed[3] = 8'd208;
        push_exp(1'b1);
        wait_drain(60);
        wait_tick();
        repeat (5) @(posedge clk25M);
        #1;
        force_off = 1'b1;
        for (int k = 0; k < NCH; k++) ed[k] = 8'd0;
        push_exp(1'b0);
        @(posedge clk25M);
        #1;
        check("force_bus", duty_bus, 0);
        check("force_ready", wif.wr_ready, 0);
        check("force_busy", busy, 0);
        wif.wr_valid = 1'b1;
        wif.wr_chan  = 4'd2;
        wif.wr_duty  = 8'd99;
        repeat (5) @(posedge clk25M);
        #1;
        wif.wr_valid = 1'b0;
        repeat (30) @(posedge clk25M);
        #1;
        force_off = 1'b0;
        @(posedge clk25M);
        #1;
        check("ready_after_force", wif.wr_ready, 1);
        repeat (60) @(posedge clk25M);
        #1;
        check("bus_idle_after_force", duty_bus, 0);
        do_write(4'd5, 8'd10);
        ed[5] = 8'd8;  push_exp(1'b1);
        ed[5] = 8'd10; push_exp(1'b1);
        wait_drain(80);

        // Asynchronous reset in the middle of a scan
        wait_tick();
        repeat (3) @(posedge clk25M);
        #3;
        for (int k = 0; k < NCH; k++) ed[k] = 8'd0;
        push_exp(1'b0);
        rst = 1'b1;
        #1;
        check("async_rst_bus", duty_bus, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_ready", wif.wr_ready, 0);
        repeat (2) @(posedge clk25M);
        #1;
        rst = 1'b0;
        check("ready_held_low", wif.wr_ready, 0);
        @(posedge clk25M);
        #1;
        check("ready_rises", wif.wr_ready, 1);

        repeat (5) @(posedge clk25M);
        #1;
        check("exp_queue_empty", exp_q.size(), 0);
        check("err_queue_empty", err_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
